// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver for the clk_pll domain.
// The line is synchronised, each bit is timed with a per-bit counter and
// decided by a 2-of-3 majority around mid-bit. Each received byte is
// presented with sticky available / overrun / framing-error flags that the
// consumer acknowledges with rx_clear_available.
module uart_rx #(
    parameter int CLK_FREQ       = 24_000_000,
    parameter int UART_BOUD_RATE = 9600
) (
    input  logic       clk_pll,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_available,
    input  logic       rx_clear_available,
    output logic       rx_framing_error,
    output logic       rx_overrun
);

    localparam int CYCLE = CLK_FREQ / UART_BOUD_RATE;
    localparam int H     = CYCLE / 2;
    localparam int CW    = $clog2(CYCLE);

    localparam logic [CW-1:0] CNT_LAST   = CW'(CYCLE - 1);
    localparam logic [CW-1:0] CNT_SAMP_A = CW'(H - 1);
    localparam logic [CW-1:0] CNT_SAMP_B = CW'(H);
    localparam logic [CW-1:0] CNT_DECIDE = CW'(H + 1);

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state;
    state_t         state_next;

    logic           rx_meta;
    logic           rx_s;
    logic [1:0]     settle;
    logic           settled;

    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic           samp_a;
    logic           samp_b;
    logic [7:0]     shift_reg;

    logic           in_frame;
    logic           stay_in_frame;
    logic           at_decide;
    logic           at_wrap;
    logic           majority;
    logic           good_stop;
    logic           bad_stop;

    assign at_decide = (cnt == CNT_DECIDE);
    assign at_wrap   = (cnt == CNT_LAST);
    assign majority  = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign settled   = settle[1];

    assign in_frame      = (state == START) || (state == DATA) || (state == STOP);
    assign stay_in_frame = (state_next == START) || (state_next == DATA) ||
                           (state_next == STOP);

    // Two-flop synchroniser for the asynchronous line; settle marks when the
    // flops hold real line samples rather than their reset value of 1.
    always_ff @(posedge clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            settle  <= 2'b00;
        end else begin
            rx_meta <= rx_pin;
            rx_s    <= rx_meta;
            settle  <= {settle[0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_HIGH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the stop-bit verdict strobes.
    always_comb begin
        state_next = state;
        good_stop  = 1'b0;
        bad_stop   = 1'b0;
        case (state)
            WAIT_HIGH: begin
                if (settled && rx_s) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (at_decide && majority) begin
                    state_next = IDLE;
                end else if (at_wrap) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (at_wrap && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (at_decide) begin
                    if (majority) begin
                        good_stop  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            default: begin
                state_next = WAIT_HIGH;
            end
        endcase
    end

    // Bit timer and bit index; both rest at zero outside a frame.
    always_ff @(posedge clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
        end else begin
            if (in_frame && stay_in_frame) begin
                cnt <= at_wrap ? '0 : cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (at_wrap) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Mid-bit samples for the majority vote and the LSB-first shift register.
    always_ff @(posedge clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            shift_reg <= 8'h00;
        end else begin
            if (in_frame && (cnt == CNT_SAMP_A)) begin
                samp_a <= rx_s;
            end
            if (in_frame && (cnt == CNT_SAMP_B)) begin
                samp_b <= rx_s;
            end
            if ((state == DATA) && at_decide) begin
                shift_reg <= {majority, shift_reg[7:1]};
            end
        end
    end

    // Output byte and sticky flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            rx_data          <= 8'h00;
            rx_available     <= 1'b0;
            rx_overrun       <= 1'b0;
            rx_framing_error <= 1'b0;
        end else begin
            if (good_stop) begin
                rx_data <= shift_reg;
            end

            if (good_stop) begin
                rx_available <= 1'b1;
            end else if (rx_clear_available) begin
                rx_available <= 1'b0;
            end

            if (good_stop && rx_available && !rx_clear_available) begin
                rx_overrun <= 1'b1;
            end else if (rx_clear_available) begin
                rx_overrun <= 1'b0;
            end

            if (bad_stop) begin
                rx_framing_error <= 1'b1;
            end else if (rx_clear_available) begin
                rx_framing_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at a shortened bit time.
// Frames come from a vector table plus hand-written corner sequences; every
// expected byte is queued with its due cycle and checked when rx_available rises.
module tb_uart_rx;

    localparam int CLK_FREQ = 24_000_000;
    localparam int BAUD     = 240_000;
    localparam int C        = CLK_FREQ / BAUD;
    localparam int H        = C / 2;
    // rx_pin falls at a negedge; two synchroniser edges, then the IDLE edge
    // that enters START, then 9*C+H+2 edges to rx_available.
    localparam int LATENCY  = 9 * C + H + 5;

    logic       clk_pll = 1'b0;
    logic       rst_n;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_available;
    logic       rx_clear_available;
    logic       rx_framing_error;
    logic       rx_overrun;

    int cyc         = 0;
    int check_count = 0;
    int error_count = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_av = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         glitch_slot;
        logic       push;
        logic [7:0] exp_data;
        logic       exp_av;
        logic       exp_fe;
        logic       exp_ov;
        logic       clear_after;
    } vec_t;

    vec_t vecs[4];

    uart_rx #(
        .CLK_FREQ       (CLK_FREQ),
        .UART_BOUD_RATE (BAUD)
    ) dut (
        .clk_pll            (clk_pll),
        .rst_n              (rst_n),
        .rx_pin             (rx_pin),
        .rx_data            (rx_data),
        .rx_available       (rx_available),
        .rx_clear_available (rx_clear_available),
        .rx_framing_error   (rx_framing_error),
        .rx_overrun         (rx_overrun)
    );

    always #5 clk_pll = ~clk_pll;

    task automatic checkByte(input string name, input logic [7:0] got, input logic [7:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int exp);
        check_count++;
        if (got != exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] exp_data,
                               input logic exp_av, input logic exp_fe, input logic exp_ov);
        checkByte({tag, "_rx_data"}, rx_data, exp_data);
        checkByte({tag, "_rx_available"}, {7'd0, rx_available}, {7'd0, exp_av});
        checkByte({tag, "_rx_framing_error"}, {7'd0, rx_framing_error}, {7'd0, exp_fe});
        checkByte({tag, "_rx_overrun"}, {7'd0, rx_overrun}, {7'd0, exp_ov});
    endtask

    // Called at a negedge; drives one full 10-slot frame, optionally with a
    // one-cycle inverted glitch landing on the DUT's centre sample of a slot.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input logic push, input int glitch_slot);
        exp_t e;
        logic b;
        if (push) begin
            e.data = data;
            e.due  = cyc + LATENCY;
            sb_q.push_back(e);
        end
        for (int j = 0; j < 10; j++) begin
            if (j == 0)      b = 1'b0;
            else if (j == 9) b = stop_bit;
            else             b = data[j-1];
            for (int c = 0; c < C; c++) begin
                rx_pin = (j == glitch_slot && c == H + 1) ? ~b : b;
                @(negedge clk_pll);
            end
        end
    endtask

    task automatic pulseClear();
        rx_clear_available = 1'b1;
        @(negedge clk_pll);
        rx_clear_available = 1'b0;
        @(negedge clk_pll);
    endtask

    // Sends a good frame with rx_clear_available high only in the cycle
    // whose edge takes the stop decision.
    task automatic sendWithClearAtDecision(input logic [7:0] data, input logic push);
        fork
            applyStimulus(data, 1'b1, push, -1);
            begin
                repeat (LATENCY - 1) @(negedge clk_pll);
                rx_clear_available = 1'b1;
                @(negedge clk_pll);
                rx_clear_available = 1'b0;
            end
        join
    endtask

    // Scoreboard monitor: every rising rx_available must match the queue head
    // in both data and cycle.
    initial begin
        forever begin
            @(posedge clk_pll);
            cyc++;
            #1;
            if (rx_available && !prev_av) begin
                if (sb_q.size() == 0) begin
                    check_count++;
                    error_count++;
                    $display("[TB] FAIL unexpected_byte: got rx_data=%h at cycle %0d, required no new byte",
                             rx_data, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkByte("sb_data", rx_data, mon_e.data);
                    checkInt("sb_latency", cyc, mon_e.due);
                end
            end
            prev_av = rx_available;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1, -1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h12, 1'b1, -1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h34, 1'b1, -1, 1'b0, 8'h34, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'hC9, 1'b1,  4, 1'b1, 8'hC9, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n              = 1'b0;
        rx_pin             = 1'b1;
        rx_clear_available = 1'b0;
        repeat (3) @(negedge clk_pll);
        checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_pll);

        $display("[TB] short low pulse on idle line");
        rx_pin = 1'b0;
        repeat (16) @(negedge clk_pll);
        rx_pin = 1'b1;
        repeat (44) @(negedge clk_pll);
        checkOutput("false_start", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] vector table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stop_bit, vecs[i].push, vecs[i].glitch_slot);
            rx_pin = 1'b1;
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_av,
                        vecs[i].exp_fe, vecs[i].exp_ov);
            if (vecs[i].clear_after) begin
                pulseClear();
                checkOutput($sformatf("vec%0d_clr", i), vecs[i].exp_data, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("[TB] framing error with line held low");
        applyStimulus(8'hA3, 1'b0, 1'b0, -1);
        repeat (2 * C) @(negedge clk_pll);
        checkOutput("framing", 8'hC9, 1'b0, 1'b1, 1'b0);
        rx_pin = 1'b1;
        repeat (20) @(negedge clk_pll);
        applyStimulus(8'h3C, 1'b1, 1'b1, -1);
        checkOutput("after_framing", 8'h3C, 1'b1, 1'b1, 1'b0);
        pulseClear();
        checkOutput("framing_clr", 8'h3C, 1'b0, 1'b0, 1'b0);

        $display("[TB] clear coincident with stop decision");
        sendWithClearAtDecision(8'h7E, 1'b1);
        checkOutput("clear_coincident", 8'h7E, 1'b1, 1'b0, 1'b0);
        sendWithClearAtDecision(8'h66, 1'b0);
        checkOutput("clear_coincident_ovr", 8'h66, 1'b1, 1'b0, 1'b0);
        pulseClear();
        checkOutput("coincident_clr", 8'h66, 1'b0, 1'b0, 1'b0);

        $display("[TB] clear held high through a frame");
        rx_clear_available = 1'b1;
        applyStimulus(8'h5A, 1'b1, 1'b1, -1);
        checkOutput("held_clear", 8'h5A, 1'b0, 1'b0, 1'b0);
        rx_clear_available = 1'b0;
        @(negedge clk_pll);

        $display("[TB] reset during a frame");
        rx_pin = 1'b0;
        repeat (5 * C) @(negedge clk_pll);
        rx_pin = 1'b1;
        repeat (H) @(negedge clk_pll);
        rst_n  = 1'b0;
        rx_pin = 1'b0;
        repeat (5) @(negedge clk_pll);
        checkOutput("in_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3 * C) @(negedge clk_pll);
        checkOutput("reset_low_line", 8'h00, 1'b0, 1'b0, 1'b0);
        rx_pin = 1'b1;
        repeat (20) @(negedge clk_pll);
        applyStimulus(8'h81, 1'b1, 1'b1, -1);
        checkOutput("after_reset", 8'h81, 1'b1, 1'b0, 1'b0);

        repeat (5) @(negedge clk_pll);
        checkInt("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
